// File: rtl/complex_adder_rr_sched.sv
// Round-robin shared complex add/sub unit: NREQ requesters, one registered result per cycle.
// Optional build macro CADD_SATURATE_EN: signed Q1.15 saturation, RES_COUT reports clamping.

module cadd_lane (
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        flag
);
  logic [15:0] bx, p0, g0, g1, p1, g2, p2, g3, p3, g4, raw;

  // Carry-in folds into bit 0 generate so the prefix tree stays uniform.
  assign bx = op ? ~b : b;
  assign p0 = a ^ bx;
  assign g0 = (a & bx) | {15'b0, p0[0] & op};

  assign g1 = g0 | (p0 & (g0 << 1));
  assign p1 = p0 & (p0 << 1);
  assign g2 = g1 | (p1 & (g1 << 2));
  assign p2 = p1 & (p1 << 2);
  assign g3 = g2 | (p2 & (g2 << 4));
  assign p3 = p2 & (p2 << 4);
  assign g4 = g3 | (p3 & (g3 << 8));

  assign raw = p0 ^ {g4[14:0], op};

`ifdef CADD_SATURATE_EN
  logic ovf;
  logic unused_cout;
  assign unused_cout = g4[15];
  // bx already carries the sign of the effective (negated) B operand.
  assign ovf  = (a[15] == bx[15]) && (raw[15] != a[15]);
  assign sum  = ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : raw;
  assign flag = ovf;
`else
  assign sum  = raw;
  assign flag = g4[15];
`endif
endmodule

module complex_adder_rr_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ-1:0]      REQ_OP,
  input  logic [NREQ*32-1:0]   REQ_A,
  input  logic [NREQ*32-1:0]   REQ_B,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [ID_W-1:0]      RES_ID,
  output logic [31:0]          RES_DATA,
  output logic [1:0]           RES_COUT
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 16;

  logic                              slot_free, any, xfer, op_sel;
  logic [ID_W-1:0]                   ptr, win, ptr_nxt;
  logic [NUM_LANES-1:0][VEC_W-1:0]   la, lb, ls;
  logic [NUM_LANES-1:0]              lf;

  assign slot_free = !RES_VALID || RES_READY;

  // Scan from ptr+NREQ-1 down to ptr so the last hit is the first in rotation order.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (REQ_VALID[j]) begin
        win = ID_W'(j);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (slot_free && any && !RST) REQ_READY[win] = 1'b1;
  end

  assign xfer    = |REQ_READY;
  assign ptr_nxt = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
  assign op_sel  = REQ_OP[win];
  assign la      = REQ_A[32*int'(win) +: 32];
  assign lb      = REQ_B[32*int'(win) +: 32];

  // Lane 1 is the real component (upper half), lane 0 the imaginary.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cadd_lane u_lane (
      .op   (op_sel),
      .a    (la[i]),
      .b    (lb[i]),
      .sum  (ls[i]),
      .flag (lf[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES_ID    <= '0;
      RES_DATA  <= '0;
      RES_COUT  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      RES_VALID <= 1'b1;
      RES_ID    <= win;
      RES_DATA  <= ls;
      RES_COUT  <= lf;
      ptr       <= ptr_nxt;
    end else if (RES_READY) begin
      RES_VALID <= 1'b0;
    end
  end
endmodule

// File: doc/complex_adder_rr_sched.md
Name: complex_adder_rr_sched

Overview:
- Round-robin scheduler that shares one 32-bit packed complex add/subtract datapath among NREQ requesters in the 64-point FFT processor.
- Requesters are butterfly stages and twiddle post-adds. Operands are packed as {real[15:0], imag[15:0]}.
- Each component is computed by a 16-bit Kogge-Stone add with a carry-in.
- The block arbitrates requests, performs A+B or A-B, and returns the registered result tagged with the requester ID over a valid/ready output handshake.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; 2^ID_W >= NREQ required

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
REQ_VALID  input  NREQ  per-requester request valid
REQ_READY  output  NREQ  per-requester accept (grant); at most one bit high
REQ_OP  input  NREQ  per-requester op: 0 = A+B, 1 = A-B
REQ_A  input  NREQ*32  operand A of requester i at [32i+31:32i]
REQ_B  input  NREQ*32  operand B of requester i at [32i+31:32i]
RES_VALID  output  1  result valid
RES_READY  input  1  downstream accepts result
RES_ID  output  ID_W  index of requester that produced the result
RES_DATA  output  32  {real_sum, imag_sum}
RES_COUT  output  2  {real flag, imag flag}; see arithmetic rules

Behaviour:
- Reset (async, RST=1): RES_VALID=0, RES_ID=0, RES_DATA=0, RES_COUT=0, rr pointer PTR=0.
  - REQ_READY is forced to 0 while RST is high.
  - Reset mid-operation discards the held result.
- Slot free: SLOT_FREE = !RES_VALID || RES_READY.
- Grant: when SLOT_FREE, the winner is the first i with REQ_VALID[i]=1, searching PTR, PTR+1, ... modulo NREQ.
  - REQ_READY[winner]=1 combinationally; all other bits are 0.
  - No valid requester, or !SLOT_FREE, gives REQ_READY=0.
- Transfer: a transfer occurs when REQ_VALID[i] && REQ_READY[i].
  - Requesters hold VALID, OP, A and B stable until accepted.
  - VALID may not be withdrawn before acceptance.
- Pointer update: on transfer, PTR <= (winner+1) mod NREQ. Otherwise PTR holds.
- Latency: exactly 1 cycle. On the clock edge of a transfer, RES_VALID<=1, RES_ID<=winner, and RES_DATA/RES_COUT are loaded with the computed result.
- Output handshake:
  - RES_VALID && RES_READY with no new transfer: RES_VALID<=0.
  - RES_VALID && RES_READY with a simultaneous new transfer: the new result replaces the old one. Back-to-back throughput is 1 result/cycle.
  - RES_VALID && !RES_READY: RES_VALID, RES_ID, RES_DATA and RES_COUT hold stable and no grant is issued.
  - RES_DATA and RES_ID hold their last values when RES_VALID=0.
- Arithmetic (per 16-bit component, real and imag independent):
  - OP=0: S = A + B, carry-in 0.
  - OP=1: S = A + ~B, carry-in 1.
  - Sum is modulo 2^16.
  - Default RES_COUT bit = carry-out of the component's 16-bit add. For OP=1, 1 means no borrow.
- Fairness: with all NREQ requesters continuously valid and RES_READY=1, grants cycle 0,1,...,NREQ-1,0,... and no requester waits more than NREQ-1 transfers.

Optional Feature:
- Macro: CADD_SATURATE_EN.
- Defined: operands are treated as signed Q1.15.
  - Signed overflow is detected per component: operand signs (after negating B for OP=1) are equal and the result sign differs.
  - Overflowing components clamp to 16'h7FFF (positive) or 16'h8000 (negative).
  - The RES_COUT bit = 1 iff that component saturated; carry-out is not reported.
- Undefined: wrap-around modulo 2^16; RES_COUT = raw carry-out as above.
- Arbitration, handshake and latency are identical in both builds.

Test Plan:
- Reset mid-operation: assert RST while RES_VALID=1 and REQ_VALID=4'b1111 -> RES_VALID=0, REQ_READY=0 immediately. After release the first grant goes to requester 0.
- Single add: req1 OP=0, A=32'h0001_7FFF, B=32'h0002_0001 -> one cycle later RES_VALID=1, RES_ID=1, RES_DATA=32'h0003_8000, RES_COUT=2'b00. With CADD_SATURATE_EN: RES_DATA=32'h0003_7FFF, RES_COUT=2'b01.
- Subtract: req2 OP=1, A=32'h0005_0000, B=32'h0003_0001 -> RES_DATA=32'h0002_FFFF, RES_COUT=2'b10 (default build).
- Round-robin: REQ_VALID=4'b1111 held, RES_READY=1 -> RES_ID sequence 0,1,2,3,0 on consecutive cycles, one REQ_READY bit per cycle.
- Backpressure: RES_READY=0 for 3 cycles with req3 pending -> RES_DATA/RES_ID stable and REQ_READY=0 throughout. Raising RES_READY grants req3 in the same cycle and its result appears next cycle.
- Sparse/wrap: PTR=3, only req0 and req2 valid -> grant req0, then req2, then req0.
